// File: rtl/cci_mpf_prim_track_pkg.sv
// Shared types for the multi-beat request/response tracker.
package cci_mpf_prim_track_pkg;

    localparam int TRACK_N_BEAT_BITS = 2;

    typedef logic [TRACK_N_BEAT_BITS-1:0] t_track_beat;

    typedef enum logic {
        TRACK_INIT,
        TRACK_RUN
    } t_track_state;

endpackage

// File: rtl/cci_mpf_prim_lutram.sv
// Simple dual-port LUTRAM: registered read address, asynchronous read data,
// one write port. Contents are not initialised.
module cci_mpf_prim_lutram
  #(
    parameter int N_ENTRIES = 32,
    parameter int N_DATA_BITS = 8
    )
   (
    input  logic clk,

    input  logic [$clog2(N_ENTRIES)-1:0] raddr,
    output logic [N_DATA_BITS-1:0] rdata,

    input  logic wen,
    input  logic [$clog2(N_ENTRIES)-1:0] waddr,
    input  logic [N_DATA_BITS-1:0] wdata
    );

    logic [N_DATA_BITS-1:0] mem [N_ENTRIES];
    logic [$clog2(N_ENTRIES)-1:0] raddr_q;

    always_ff @(posedge clk) begin
        raddr_q <= raddr;
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr_q];

endmodule

// File: rtl/cci_mpf_prim_track_multi_beat_cnt.sv
// Beat counter memory for the tracker: T1 eop/sop/beat computation with a
// T2->T1 bypass, and the T2 write-back of the updated count.
module cci_mpf_prim_track_multi_beat_cnt
    import cci_mpf_prim_track_pkg::*;
  #(
    parameter int N_ENTRIES = 128,
    parameter int N_BEAT_BITS = 2
    )
   (
    input  logic clk,
    input  logic reset,

    input  logic sweep_en,
    input  logic [$clog2(N_ENTRIES)-1:0] sweep_idx,

    input  logic [$clog2(N_ENTRIES)-1:0] rsp_idx,

    input  logic t1_en,
    input  logic [$clog2(N_ENTRIES)-1:0] t1_idx,
    input  logic t1_packed,
    input  logic [N_BEAT_BITS-1:0] t1_len,
    input  logic t1_valid,

    output logic hit,
    output logic sop,
    output logic eop,
    output logic [N_BEAT_BITS-1:0] beat,

    output logic t2_close,
    output logic [$clog2(N_ENTRIES)-1:0] t2_idx
    );

    logic [N_BEAT_BITS-1:0] cnt_rd;
    logic [N_BEAT_BITS-1:0] cnt_cur;
    logic [N_BEAT_BITS-1:0] cnt_next;
    logic [N_BEAT_BITS-1:0] t2_cnt;
    logic t2_wen;
    logic t2_eop;
    logic byp;

    logic ram_wen;
    logic [$clog2(N_ENTRIES)-1:0] ram_waddr;
    logic [N_BEAT_BITS-1:0] ram_wdata;

    always_comb begin
        ram_wen = sweep_en || t2_wen;
        ram_waddr = sweep_en ? sweep_idx : t2_idx;
        ram_wdata = sweep_en ? '0 : t2_cnt;
    end

    cci_mpf_prim_lutram
      #(
        .N_ENTRIES(N_ENTRIES),
        .N_DATA_BITS(N_BEAT_BITS)
        )
      cnt_ram
       (
        .clk(clk),
        .raddr(rsp_idx),
        .rdata(cnt_rd),
        .wen(ram_wen),
        .waddr(ram_waddr),
        .wdata(ram_wdata)
        );

    // The T2 write lands after the T1 read, so a beat following directly on
    // the same tag must take the in-flight count and valid state instead.
    always_comb begin
        byp = t2_wen && (t2_idx == t1_idx);
        cnt_cur = byp ? t2_cnt : cnt_rd;
        hit = t1_valid && !(byp && t2_eop);
        eop = t1_packed || (cnt_cur == t1_len);
        sop = t1_packed || (cnt_cur == '0);
        beat = t1_packed ? t1_len : cnt_cur;
        cnt_next = eop ? '0 : cnt_cur + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            t2_wen <= 1'b0;
        end
        else begin
            t2_wen <= t1_en && hit;
        end
        t2_idx <= t1_idx;
        t2_cnt <= cnt_next;
        t2_eop <= eop;
    end

    assign t2_close = t2_wen && t2_eop;

endmodule

// File: rtl/cci_mpf_prim_track_multi_beat.sv
// Multi-beat request/response tracker: records packet length per tag and
// annotates each response beat with SOP, EOP and beat index.
module cci_mpf_prim_track_multi_beat
    import cci_mpf_prim_track_pkg::*;
  #(
    parameter int N_ENTRIES = 128,
    parameter int N_BEAT_BITS = 2
    )
   (
    input  logic clk,
    input  logic reset,
    output logic rdy,

    input  logic req_en,
    input  logic [$clog2(N_ENTRIES)-1:0] req_idx,
    input  logic [N_BEAT_BITS-1:0] req_len,

    input  logic rsp_en,
    input  logic [$clog2(N_ENTRIES)-1:0] rsp_idx,
    input  logic rsp_packed,

    output logic out_en,
    output logic [$clog2(N_ENTRIES)-1:0] out_idx,
    output logic out_sop,
    output logic out_eop,
    output logic [N_BEAT_BITS-1:0] out_beat,
    output logic [N_BEAT_BITS-1:0] out_len,

    output logic [$clog2(N_ENTRIES+1)-1:0] outstanding,
    output logic idle,
    output logic err_req_busy,
    output logic err_rsp_idle
    );

    localparam int IDX_BITS = $clog2(N_ENTRIES);

    t_track_state state;
    t_track_state state_next;
    logic [IDX_BITS-1:0] sweep_idx;
    logic sweep_en;

    logic [N_ENTRIES-1:0] valid;

    logic req_q_en;
    logic [IDX_BITS-1:0] req_q_idx;
    logic [N_BEAT_BITS-1:0] req_q_len;
    logic req_busy;
    logic req_inc;

    logic t1_en;
    logic [IDX_BITS-1:0] t1_idx;
    logic t1_packed;
    logic [N_BEAT_BITS-1:0] t1_len;

    logic hit;
    logic sop;
    logic eop;
    logic [N_BEAT_BITS-1:0] beat;
    logic t2_close;
    logic [IDX_BITS-1:0] t2_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= TRACK_INIT;
            sweep_idx <= '0;
        end
        else begin
            state <= state_next;
            if (state == TRACK_INIT) begin
                sweep_idx <= sweep_idx + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            TRACK_INIT: if (&sweep_idx) state_next = TRACK_RUN;
            TRACK_RUN:  state_next = TRACK_RUN;
            default:    state_next = TRACK_INIT;
        endcase
    end

    assign rdy = (state == TRACK_RUN);
    assign sweep_en = (state == TRACK_INIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q_en <= 1'b0;
            t1_en <= 1'b0;
        end
        else begin
            req_q_en <= req_en && rdy;
            t1_en <= rsp_en && rdy;
        end
        req_q_idx <= req_idx;
        req_q_len <= req_len;
        t1_idx <= rsp_idx;
        t1_packed <= rsp_packed;
    end

    cci_mpf_prim_lutram
      #(
        .N_ENTRIES(N_ENTRIES),
        .N_DATA_BITS(N_BEAT_BITS)
        )
      len_ram
       (
        .clk(clk),
        .raddr(rsp_idx),
        .rdata(t1_len),
        .wen(req_q_en),
        .waddr(req_q_idx),
        .wdata(req_q_len)
        );

    cci_mpf_prim_track_multi_beat_cnt
      #(
        .N_ENTRIES(N_ENTRIES),
        .N_BEAT_BITS(N_BEAT_BITS)
        )
      cnt
       (
        .clk(clk),
        .reset(reset),
        .sweep_en(sweep_en),
        .sweep_idx(sweep_idx),
        .rsp_idx(rsp_idx),
        .t1_en(t1_en),
        .t1_idx(t1_idx),
        .t1_packed(t1_packed),
        .t1_len(t1_len),
        .t1_valid(valid[t1_idx]),
        .hit(hit),
        .sop(sop),
        .eop(eop),
        .beat(beat),
        .t2_close(t2_close),
        .t2_idx(t2_idx)
        );

    // A tag closing at T2 in the same cycle is free for the new request.
    assign req_busy = valid[req_q_idx] && !(t2_close && (t2_idx == req_q_idx));
    assign req_inc = req_q_en && !req_busy;

    always_ff @(posedge clk) begin
        if (sweep_en) begin
            valid[sweep_idx] <= 1'b0;
        end
        else begin
            if (t2_close) valid[t2_idx] <= 1'b0;
            if (req_q_en) valid[req_q_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_en <= 1'b0;
            out_idx <= '0;
            out_sop <= 1'b0;
            out_eop <= 1'b0;
            out_beat <= '0;
            out_len <= '0;
            outstanding <= '0;
            err_req_busy <= 1'b0;
            err_rsp_idle <= 1'b0;
        end
        else begin
            out_en <= t1_en;
            if (t1_en) begin
                out_idx <= t1_idx;
                out_sop <= hit ? sop : 1'b1;
                out_eop <= hit ? eop : 1'b1;
                out_beat <= hit ? beat : '0;
                out_len <= hit ? t1_len : '0;
                if (!hit) err_rsp_idle <= 1'b1;
            end
            if (req_q_en && req_busy) err_req_busy <= 1'b1;

            if (req_inc && !t2_close && (outstanding != '1)) begin
                outstanding <= outstanding + 1'b1;
            end
            else if (!req_inc && t2_close && (outstanding != '0)) begin
                outstanding <= outstanding - 1'b1;
            end
        end
    end

    assign idle = (outstanding == '0) && !t1_en && !out_en;

endmodule

// File: tb/tb_cci_mpf_prim_track_multi_beat.sv
// Scoreboard bench for cci_mpf_prim_track_multi_beat: directed requests and
// response beats, expected annotations queued and checked by a monitor.
module tb_cci_mpf_prim_track_multi_beat;

    logic clk;
    logic reset;
    logic rdy;
    logic req_en;
    logic [6:0] req_idx;
    logic [1:0] req_len;
    logic rsp_en;
    logic [6:0] rsp_idx;
    logic rsp_packed;
    logic out_en;
    logic [6:0] out_idx;
    logic out_sop;
    logic out_eop;
    logic [1:0] out_beat;
    logic [1:0] out_len;
    logic [7:0] outstanding;
    logic idle;
    logic err_req_busy;
    logic err_rsp_idle;

    typedef struct packed {
        logic [6:0] idx;
        logic       sop;
        logic       eop;
        logic [1:0] beat;
        logic [1:0] len;
    } exp_t;

    exp_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    cci_mpf_prim_track_multi_beat
      #(
        .N_ENTRIES(128),
        .N_BEAT_BITS(2)
        )
      dut
       (
        .clk(clk),
        .reset(reset),
        .rdy(rdy),
        .req_en(req_en),
        .req_idx(req_idx),
        .req_len(req_len),
        .rsp_en(rsp_en),
        .rsp_idx(rsp_idx),
        .rsp_packed(rsp_packed),
        .out_en(out_en),
        .out_idx(out_idx),
        .out_sop(out_sop),
        .out_eop(out_eop),
        .out_beat(out_beat),
        .out_len(out_len),
        .outstanding(outstanding),
        .idle(idle),
        .err_req_busy(err_req_busy),
        .err_rsp_idle(err_rsp_idle)
        );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every annotated beat must match the oldest queued expectation.
    always @(negedge clk) begin
        if (out_en === 1'b1) begin
            exp_t act;
            exp_t e;
            act = {out_idx, out_sop, out_eop, out_beat, out_len};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL beat_unexpected: got idx=%0d sop=%0d eop=%0d beat=%0d len=%0d expected no beat",
                         out_idx, out_sop, out_eop, out_beat, out_len);
            end
            else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    n_bad++;
                    $display("FAIL beat_annot: got idx=%0d sop=%0d eop=%0d beat=%0d len=%0d expected idx=%0d sop=%0d eop=%0d beat=%0d len=%0d",
                             out_idx, out_sop, out_eop, out_beat, out_len,
                             e.idx, e.sop, e.eop, e.beat, e.len);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        req_en = 1'b0;
        rsp_en = 1'b0;
        rsp_packed = 1'b0;
    endtask

    task automatic step_nop();
        cyc();
    endtask

    task automatic step_req(input int idx, input int len);
        cyc();
        req_en = 1'b1;
        req_idx = 7'(idx);
        req_len = 2'(len);
    endtask

    task automatic step_rsp(input int idx, input bit pk, input bit s, input bit e,
                            input int b, input int l, input bit push = 1'b1);
        exp_t x;
        cyc();
        rsp_en = 1'b1;
        rsp_idx = 7'(idx);
        rsp_packed = pk;
        x.idx = 7'(idx);
        x.sop = s;
        x.eop = e;
        x.beat = 2'(b);
        x.len = 2'(l);
        if (push) exp_q.push_back(x);
    endtask

    // rdy must stay low for exactly 128 cycles after reset drops, then rise.
    task automatic wait_init();
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            chk("init_rdy_low", rdy, 0);
            chk("init_idle", idle, 1);
            chk("init_outstanding", outstanding, 0);
        end
        @(negedge clk);
        chk("init_rdy_high", rdy, 1);
    endtask

    initial begin
        reset = 1'b1;
        req_en = 1'b0;
        req_idx = '0;
        req_len = '0;
        rsp_en = 1'b0;
        rsp_idx = '0;
        rsp_packed = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy", rdy, 0);
        chk("rst_out_en", out_en, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_idle", idle, 1);
        chk("rst_err_req_busy", err_req_busy, 0);
        chk("rst_err_rsp_idle", err_rsp_idle, 0);
        chk("rst_out_fields", {out_idx, out_sop, out_eop, out_beat, out_len}, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_init();

        // Four-beat packet, consecutive beats on one tag.
        step_req(5, 3);
        step_nop();
        step_rsp(5, 0, 1, 0, 0, 3);
        chk("multi_outstanding_open", outstanding, 1);
        chk("multi_not_idle", idle, 0);
        step_rsp(5, 0, 0, 0, 1, 3);
        step_rsp(5, 0, 0, 0, 2, 3);
        step_rsp(5, 0, 0, 1, 3, 3);
        repeat (5) step_nop();
        chk("multi_outstanding_closed", outstanding, 0);

        // Packed response, then a stray response to the closed tag.
        step_req(7, 2);
        step_nop();
        step_rsp(7, 1, 1, 1, 2, 2);
        step_nop();
        step_nop();
        chk("packed_no_idle_err", err_rsp_idle, 0);
        step_rsp(7, 0, 1, 1, 0, 0);
        repeat (4) step_nop();
        chk("stray_err_rsp_idle", err_rsp_idle, 1);
        chk("packed_outstanding", outstanding, 0);

        // Interleaved two-beat packets on tags 2 and 3.
        step_req(2, 1);
        step_req(3, 1);
        step_nop();
        step_rsp(2, 0, 1, 0, 0, 1);
        step_rsp(3, 0, 1, 0, 0, 1);
        step_rsp(2, 0, 0, 1, 1, 1);
        step_rsp(3, 0, 0, 1, 1, 1);
        repeat (5) step_nop();
        chk("interleave_outstanding", outstanding, 0);

        // Double request to tag 9.
        step_req(9, 2);
        step_nop();
        step_nop();
        chk("busy_before", err_req_busy, 0);
        step_req(9, 2);
        step_nop();
        step_nop();
        chk("busy_after", err_req_busy, 1);
        chk("busy_outstanding", outstanding, 1);

        // Three open packets, reset while beats are in flight.
        step_req(10, 3);
        step_req(11, 3);
        step_nop();
        step_nop();
        chk("pre_reset_outstanding", outstanding, 3);
        step_rsp(10, 0, 1, 0, 0, 3);
        step_rsp(11, 0, 1, 0, 0, 3);
        step_rsp(9, 0, 1, 0, 0, 2, 1'b0);
        cyc();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("flush_out_en", out_en, 0);
        chk("flush_outstanding", outstanding, 0);
        chk("flush_err_req_busy", err_req_busy, 0);
        chk("flush_err_rsp_idle", err_rsp_idle, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_init();

        // Previously open tag starts again at beat 0.
        step_req(10, 1);
        step_nop();
        step_rsp(10, 0, 1, 0, 0, 1);
        step_rsp(10, 0, 0, 1, 1, 1);
        repeat (5) step_nop();
        chk("restart_outstanding", outstanding, 0);
        chk("restart_idle", idle, 1);
        chk("restart_no_err", err_rsp_idle, 0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cci_mpf_prim_track_multi_beat.md
# cci_mpf_prim_track_multi_beat

Parametrised multi-beat request/response tracker for MPF shims. It records the packet length of each tagged request and follows the response beats for that tag. Every response beat is annotated with SOP, EOP and a beat index, and packed (single-flit) responses are accepted. Response beats and packet completion are counted, and protocol violations are flagged. Read and write EOP shims instantiate one tracker per channel, and VTP and WRO use the per-beat annotations.

## Interface
Parameters:
- N_ENTRIES, 128: tag space. Index width is $clog2(N_ENTRIES). Must be a power of 2 and ≥ 4.
- N_BEAT_BITS, 2: length field width. Lengths are encoded as beats−1, so the maximum packet is 2^N_BEAT_BITS beats.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- rdy  out  1  init sweep done. req_en/rsp_en are ignored while rdy=0.
- req_en  in  1  new request.
- req_idx  in  IDX  request tag.
- req_len  in  N_BEAT_BITS  beats−1.
- rsp_en  in  1  response beat.
- rsp_idx  in  IDX  response tag.
- rsp_packed  in  1  response covers the whole packet.
- out_en  out  1  annotated beat valid.
- out_idx  out  IDX  tag of the annotated beat.
- out_sop, out_eop  out  1 each  first / last beat of the packet.
- out_beat  out  N_BEAT_BITS  0-based beat number. For a packed response this is the packet's beats−1.
- out_len  out  N_BEAT_BITS  packet beats−1.
- outstanding  out  $clog2(N_ENTRIES+1)  number of open packets.
- idle  out  1  outstanding==0 and no response in the pipeline.
- err_req_busy  out  1  sticky: a request was made to an already-open tag.
- err_rsp_idle  out  1  sticky: a response arrived for a closed tag.

## Operation
- Per-entry state: valid bit, len, cnt (beats received). len and cnt are stored in separate LUTRAMs, so each memory has a single writer.
- FSM:
  - INIT (entered on reset): a sweep counter walks every entry, clearing valid and cnt, one entry per cycle.
  - When the counter reaches N_ENTRIES−1, the FSM moves to RUN and rdy=1 on the next cycle.
  - RUN is left only by reset.
- Request path:
  - Inputs are registered one cycle. The entry write (len, valid=1) lands at T1.
  - If the entry is already valid, err_req_busy is set and the entry is overwritten.
- Response path:
  - T0: read address rsp_idx.
  - T1: compute eop = packed || cnt==len; new cnt = eop ? 0 : cnt+1; clear valid on eop.
  - T2: write back, and register the out_* signals.
- Bypass: when the T1 beat has the same tag as the T2 write, the T1 beat uses the T2 write data instead of the RAM read. Back-to-back beats to one tag must count 0,1,2,3.
- Annotation: out_sop = packed || cnt==0. A packed response drives out_sop=out_eop=1 with out_beat=len.
- A response to an invalid entry:
  - sets err_rsp_idle;
  - is still annotated with sop=eop=1, beat=0, len=0;
  - leaves the entry unchanged.
- outstanding:
  - +1 for each accepted req_en at T1;
  - −1 for each eop at T2;
  - both in the same cycle leave it unchanged;
  - never wraps.
- Protocol precondition: a response to a tag arrives ≥2 cycles after its request. Violating this is undefined. Benches must not generate it.

## Timing
- Annotation latency is 2 cycles: rsp_en at cycle N gives out_en at cycle N+2. One beat per cycle is accepted with no stalls.
- Request to tag-visible latency is 1 cycle.
- Reset values:
  - rdy=0, out_en=0, outstanding=0, idle=1;
  - err_* = 0;
  - out_idx/sop/eop/beat/len = 0.
- INIT lasts N_ENTRIES cycles after reset deasserts, and rdy rises in the next cycle.
- Reset asserted mid-operation:
  - flushes the T1/T2 pipeline (out_en=0 the next cycle);
  - restarts INIT;
  - drops all open packets.
- Simultaneous req_en and rsp_en to different tags: both are processed in full.

## Structure
- Shared package cci_mpf_prim_track_pkg holds t_track_beat (logic [N_BEAT_BITS-1:0]) and the FSM enum t_track_state {TRACK_INIT, TRACK_RUN}.
- The len and cnt memories use the existing cci_mpf_prim_lutram (no init variant). Clearing is done by this block's own sweep.
- One sub-module, cci_mpf_prim_track_multi_beat_cnt, contains the cnt RAM plus the T2 write, bypass and eop computation.

## Test plan
- Reset, then wait: rdy=0 for exactly 128 cycles and then 1; idle=1 and outstanding=0 throughout.
- req idx5 len3, then 4 rsp idx5 on consecutive cycles: out_beat 0,1,2,3; sop only on the first; eop only on the fourth; outstanding 1→0.
- req idx7 len2, then one rsp idx7 packed=1: sop=eop=1, beat=2, len=2, tag cleared. A further rsp idx7 sets err_rsp_idle.
- Interleave len1 packets on idx2 and idx3 (rsp 2,3,2,3): eop on the 3rd and 4th beats, beats 0,0,1,1, bypass not falsely applied.
- req idx9 twice without a response: err_req_busy=1 and outstanding=1.
- Reset asserted while 3 packets are open mid-beat: out_en=0 the next cycle, outstanding=0, INIT repeats, and a new req/rsp on a previously open tag gives sop at beat 0.
